trace_capture_buffer: RTL

TRACE_CAPTURE_BUFFER -- requirements
Module: trace_capture_buffer

---
 rtl/trace_capture_buffer_pkg.sv | 13 +
 rtl/trace_bank_ram.sv | 25 ++
 rtl/trace_capture_buffer.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/trace_capture_buffer_pkg.sv
// Shared defaults and types for the double-banked trace capture buffer.
// The capture FSM states and reader bus width are defined here.
package trace_capture_buffer_pkg;
   localparam int DEPTH_DEF    = 320;
   localparam int SAMPLE_W_DEF = 12;
   localparam int RD_W         = 32;

   typedef enum logic [1:0] {
      ST_ARMED = 2'd0,
      ST_FILL  = 2'd1,
      ST_FULL  = 2'd2
   } cap_state_t;
endpackage

// File: rtl/trace_bank_ram.sv
// One trace bank: simple dual-port RAM with one write port and a registered read.
// Read data appears one cycle after the address; contents are never reset.
module trace_bank_ram #(
   parameter int DEPTH  = 320,
   parameter int DATA_W = 12
) (
   input  logic                     clock,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic [$clog2(DEPTH)-1:0] rd_addr,
   output logic [DATA_W-1:0]        rd_data
);
   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rd_q;

   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      rd_q <= mem[rd_addr];
   end

   assign rd_data = rd_q;
endmodule

// File: rtl/trace_capture_buffer.sv
// Decimating triggered trace capture into a back bank, swapped to the display on frame_sync.
// rd_data has one cycle of latency and reads zero when no trace or address out of range.
module trace_capture_buffer
   import trace_capture_buffer_pkg::*;
#(
   parameter int DEPTH        = DEPTH_DEF,
   parameter int SAMPLE_W     = SAMPLE_W_DEF,
   parameter int AUTO_TIMEOUT = 1024
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                sample_valid,
   input  logic [SAMPLE_W-1:0] sample_data,
   input  logic [7:0]          decim,
   input  logic [SAMPLE_W-1:0] threshold,
   input  logic                frame_sync,
   input  logic [11:0]         rd_addr,
   output logic [RD_W-1:0]     rd_data,
   output logic                frame_valid,
   output logic [15:0]         overflow_cnt
);
   localparam int AW  = $clog2(DEPTH);
   localparam int ACW = $clog2(AUTO_TIMEOUT + 1);

   cap_state_t          state_q, state_d;
   logic                front_sel_q, front_sel_d;
   logic                frame_valid_q, frame_valid_d;
   logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
   logic [7:0]          dec_cnt_q, dec_cnt_d;
   logic [ACW-1:0]      auto_cnt_q, auto_cnt_d;
   logic [SAMPLE_W-1:0] prev_q, prev_d;
   logic [15:0]         ovf_q, ovf_d;
   logic                rd_ok_q, rd_ok_d;
   logic                rd_sel_q, rd_sel_d;

   logic                accept;
   logic [7:0]          d_eff;
   logic                wr_en;
   logic [AW-1:0]       wr_addr;
   logic [SAMPLE_W-1:0] bank0_rd, bank1_rd;

   always_comb begin
      state_d       = state_q;
      front_sel_d   = front_sel_q;
      frame_valid_d = frame_valid_q;
      wr_ptr_d      = wr_ptr_q;
      dec_cnt_d     = dec_cnt_q;
      auto_cnt_d    = auto_cnt_q;
      prev_d        = prev_q;
      ovf_d         = ovf_q;
      wr_en         = 1'b0;
      wr_addr       = wr_ptr_q;
      d_eff         = (decim == 8'd0) ? 8'd1 : decim;
      accept        = sample_valid && (dec_cnt_q == 8'd0);

      // >= rather than == so a shrinking decim still wraps cleanly.
      if (sample_valid) begin
         dec_cnt_d = (dec_cnt_q >= d_eff - 8'd1) ? 8'd0 : dec_cnt_q + 8'd1;
      end
      if (accept) begin
         prev_d = sample_data;
      end

      case (state_q)
         ST_ARMED: begin
            // The accepted sample that brings the auto count to AUTO_TIMEOUT forces the trigger.
            if (accept) begin
               if (((prev_q < threshold) && (sample_data >= threshold)) ||
                   (auto_cnt_q == ACW'(AUTO_TIMEOUT - 1))) begin
                  wr_en      = 1'b1;
                  wr_addr    = '0;
                  wr_ptr_d   = AW'(1);
                  auto_cnt_d = '0;
                  state_d    = ST_FILL;
               end else begin
                  auto_cnt_d = auto_cnt_q + ACW'(1);
               end
            end
         end
         ST_FILL: begin
            if (accept) begin
               wr_en = 1'b1;
               if (wr_ptr_q == AW'(DEPTH - 1)) begin
                  state_d = ST_FULL;
               end else begin
                  wr_ptr_d = wr_ptr_q + AW'(1);
               end
            end
         end
         ST_FULL: begin
            if (accept && (ovf_q != 16'hFFFF)) begin
               ovf_d = ovf_q + 16'd1;
            end
            if (frame_sync) begin
               front_sel_d   = ~front_sel_q;
               frame_valid_d = 1'b1;
               wr_ptr_d      = '0;
               auto_cnt_d    = '0;
               state_d       = ST_ARMED;
            end
         end
         default: state_d = ST_ARMED;
      endcase

      rd_ok_d  = frame_valid_q && (32'(rd_addr) < DEPTH);
      rd_sel_d = front_sel_q;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q       <= ST_ARMED;
         front_sel_q   <= 1'b0;
         frame_valid_q <= 1'b0;
         wr_ptr_q      <= '0;
         dec_cnt_q     <= '0;
         auto_cnt_q    <= '0;
         prev_q        <= '0;
         ovf_q         <= '0;
         rd_ok_q       <= 1'b0;
         rd_sel_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         front_sel_q   <= front_sel_d;
         frame_valid_q <= frame_valid_d;
         wr_ptr_q      <= wr_ptr_d;
         dec_cnt_q     <= dec_cnt_d;
         auto_cnt_q    <= auto_cnt_d;
         prev_q        <= prev_d;
         ovf_q         <= ovf_d;
         rd_ok_q       <= rd_ok_d;
         rd_sel_q      <= rd_sel_d;
      end
   end

   // Capture always targets the bank the display is not reading.
   trace_bank_ram #(.DEPTH(DEPTH), .DATA_W(SAMPLE_W)) u_bank0 (
      .clock   (clock),
      .wr_en   (wr_en && front_sel_q),
      .wr_addr (wr_addr),
      .wr_data (sample_data),
      .rd_addr (rd_addr[AW-1:0]),
      .rd_data (bank0_rd)
   );

   trace_bank_ram #(.DEPTH(DEPTH), .DATA_W(SAMPLE_W)) u_bank1 (
      .clock   (clock),
      .wr_en   (wr_en && !front_sel_q),
      .wr_addr (wr_addr),
      .wr_data (sample_data),
      .rd_addr (rd_addr[AW-1:0]),
      .rd_data (bank1_rd)
   );

   assign rd_data      = rd_ok_q ? {{(RD_W - SAMPLE_W){1'b0}}, (rd_sel_q ? bank1_rd : bank0_rd)}
                                 : '0;
   assign frame_valid  = frame_valid_q;
   assign overflow_cnt = ovf_q;
endmodule
